// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction source,
// the alu_sequencer controller and the register-file/shifter/ALU datapath.
interface alu_sequencer_if;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic [15:0] sximm8;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        bad;

    // Controller side: accepts the start handshake, drives every datapath control.
    modport master (
        input  s, instr,
        output w, readnum, writenum, write, vsel, sximm8,
               loada, loadb, loadc, loads, asel, shift, ALUop, bad
    );

    // Harness/datapath side.
    modport slave (
        output s, instr,
        input  w, readnum, writenum, write, vsel, sximm8,
               loada, loadb, loadc, loads, asel, shift, ALUop, bad
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle Moore controller: latches one 16-bit instruction on a start
// handshake, decodes it and steps the datapath through read, execute and
// write-back, then returns to idle with w=1.
module alu_sequencer (
    input  logic            clk,
    input  logic            reset_n,
    alu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GETA   = 3'd2,
        S_GETB   = 3'd3,
        S_EXEC   = 3'd4,
        S_WBACK  = 3'd5,
        S_WIMM   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    // State and instruction register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state decode; IR only loads when a start is accepted in WAIT.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm)               state_d = S_WIMM;
                else if (is_mov_reg || is_mvn) state_d = S_GETB;
                else if (is_alu)              state_d = S_GETA;
                else                          state_d = S_BAD;
            end
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_EXEC;
            S_EXEC:  state_d = is_cmp ? S_WAIT : S_WBACK;
            S_WBACK: state_d = S_WAIT;
            S_WIMM:  state_d = S_WAIT;
            S_BAD:   state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // Moore outputs decoded from state and IR only.
    always_comb begin
        bus.w        = 1'b0;
        bus.readnum  = '0;
        bus.writenum = '0;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.shift    = '0;
        bus.ALUop    = '0;
        bus.bad      = 1'b0;
        bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
        case (state_q)
            S_WAIT: bus.w = 1'b1;
            S_GETA: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            S_GETB: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            S_EXEC: begin
                bus.loadc = 1'b1;
                bus.shift = sh;
                if (is_alu) begin
                    bus.ALUop = op;
                end else begin
                    bus.ALUop = 2'b00;
                    bus.asel  = 1'b1;
                end
                bus.loads = is_cmp;
            end
            S_WBACK: begin
                bus.writenum = rd;
                bus.vsel     = 1'b0;
                bus.write    = 1'b1;
            end
            S_WIMM: begin
                bus.writenum = rn;
                bus.vsel     = 1'b1;
                bus.write    = 1'b1;
            end
            S_BAD: bus.bad = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer: per-cycle comparison of every
// control output against hand-derived Moore sequences.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Packed view of outputs:
    // {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, shift, ALUop, bad}
    function automatic logic [18:0] outs();
        return {bus.w, bus.readnum, bus.writenum, bus.write, bus.vsel,
                bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
                bus.shift, bus.ALUop, bus.bad};
    endfunction

    function automatic logic [18:0] v(input logic w_, input logic [2:0] rn,
                                      input logic [2:0] wn, input logic wr,
                                      input logic vs, input logic la,
                                      input logic lb, input logic lc,
                                      input logic ls, input logic as_,
                                      input logic [1:0] sh, input logic [1:0] op,
                                      input logic bd);
        return {w_, rn, wn, wr, vs, la, lb, lc, ls, as_, sh, op, bd};
    endfunction

    logic [18:0] IDLE;
    logic [18:0] DEC;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with a one-cycle start pulse; returns in DECODE.
    task automatic accept(input logic [15:0] i);
        bus.instr = i;
        bus.s     = 1'b1;
        step();
        bus.s     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.s     = 1'b0;
        bus.instr = 16'h0000;
        step();
        step();
        checks++;
        if (outs() !== IDLE) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=%h", outs(), IDLE);
        end
        checks++;
        if (bus.sximm8 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_sximm8 got=%h exp=0000", bus.sximm8);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (outs() !== IDLE || bus.sximm8 !== 16'h0000) begin
                failures++;
                $display("FAIL idle_c%0d got=%h/%h exp=%h/0000", k, outs(), bus.sximm8, IDLE);
            end
        end
    endtask

    task automatic test_mov_imm(input logic [15:0] i, input logic [2:0] wn,
                                input logic [15:0] sx);
        logic [18:0] e[$];
        e = '{DEC, v(0,0,wn,1,1,0,0,0,0,0,2'b00,2'b00,0), IDLE};
        accept(i);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== sx) begin
                failures++;
                $display("FAIL movimm_%h_c%0d got=%h/%h exp=%h/%h", i, k, outs(), bus.sximm8, e[k], sx);
            end
            step();
        end
    endtask

    task automatic test_add();
        logic [18:0] e[$];
        e = '{DEC,
              v(0,3'd1,0,0,0,1,0,0,0,0,2'b00,2'b00,0),
              v(0,3'd0,0,0,0,0,1,0,0,0,2'b00,2'b00,0),
              v(0,0,0,0,0,0,0,1,0,0,2'b01,2'b00,0),
              v(0,0,3'd2,1,0,0,0,0,0,0,2'b00,2'b00,0),
              IDLE};
        accept(16'hA148);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== 16'h0048) begin
                failures++;
                $display("FAIL add_c%0d got=%h/%h exp=%h/0048", k, outs(), bus.sximm8, e[k]);
            end
            step();
        end
    endtask

    task automatic test_and();
        logic [18:0] e[$];
        e = '{DEC,
              v(0,3'd2,0,0,0,1,0,0,0,0,2'b00,2'b00,0),
              v(0,3'd3,0,0,0,0,1,0,0,0,2'b00,2'b00,0),
              v(0,0,0,0,0,0,0,1,0,0,2'b01,2'b10,0),
              v(0,0,3'd5,1,0,0,0,0,0,0,2'b00,2'b00,0),
              IDLE};
        accept(16'hB2AB);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== 16'hFFAB) begin
                failures++;
                $display("FAIL and_c%0d got=%h/%h exp=%h/ffab", k, outs(), bus.sximm8, e[k]);
            end
            step();
        end
    endtask

    // s is toggled and instr changed throughout; neither may disturb the CMP.
    task automatic test_cmp_s_ignored();
        logic [18:0] e[$];
        e = '{DEC,
              v(0,3'd0,0,0,0,1,0,0,0,0,2'b00,2'b00,0),
              v(0,3'd1,0,0,0,0,1,0,0,0,2'b00,2'b00,0),
              v(0,0,0,0,0,0,0,1,1,0,2'b00,2'b01,0),
              IDLE,
              IDLE};
        accept(16'hA801);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== 16'h0001) begin
                failures++;
                $display("FAIL cmp_c%0d got=%h/%h exp=%h/0001", k, outs(), bus.sximm8, e[k]);
            end
            bus.s     = (k < 4) ? ((k % 2) == 0) : 1'b0;
            bus.instr = 16'hD0FF;
            step();
        end
    endtask

    task automatic test_mov_reg(input logic [15:0] i, input logic [2:0] rm,
                                input logic [2:0] rd, input logic [15:0] sx);
        logic [18:0] e[$];
        e = '{DEC,
              v(0,rm,0,0,0,0,1,0,0,0,2'b00,2'b00,0),
              v(0,0,0,0,0,0,0,1,0,1,2'b10,2'b00,0),
              v(0,0,rd,1,0,0,0,0,0,0,2'b00,2'b00,0),
              IDLE};
        accept(i);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== sx) begin
                failures++;
                $display("FAIL movreg_%h_c%0d got=%h/%h exp=%h/%h", i, k, outs(), bus.sximm8, e[k], sx);
            end
            step();
        end
    endtask

    task automatic test_mvn();
        logic [18:0] e[$];
        e = '{DEC,
              v(0,3'd0,0,0,0,0,1,0,0,0,2'b00,2'b00,0),
              v(0,0,0,0,0,0,0,1,0,0,2'b00,2'b11,0),
              v(0,0,3'd3,1,0,0,0,0,0,0,2'b00,2'b00,0),
              IDLE};
        accept(16'hB860);
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== 16'h0060) begin
                failures++;
                $display("FAIL mvn_c%0d got=%h/%h exp=%h/0060", k, outs(), bus.sximm8, e[k]);
            end
            step();
        end
    endtask

    task automatic test_bad();
        logic [15:0] undef[3];
        logic [18:0] e[$];
        undef = '{16'hE000, 16'hD800, 16'hC800};
        e = '{DEC, v(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,1), IDLE, IDLE};
        for (int n = 0; n < 3; n++) begin
            accept(undef[n]);
            for (int k = 0; k < e.size(); k++) begin
                checks++;
                if (outs() !== e[k]) begin
                    failures++;
                    $display("FAIL bad_%h_c%0d got=%h exp=%h", undef[n], k, outs(), e[k]);
                end
                step();
            end
        end
    endtask

    task automatic test_reset_mid();
        accept(16'hA148);
        step();
        step();
        checks++;
        if (outs() !== v(0,3'd0,0,0,0,0,1,0,0,0,2'b00,2'b00,0)) begin
            failures++;
            $display("FAIL midrst_getb got=%h", outs());
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs() !== IDLE || bus.sximm8 !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_abort got=%h/%h exp=%h/0000", outs(), bus.sximm8, IDLE);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 1) reset_n = 1'b1;
            checks++;
            if (outs() !== IDLE) begin
                failures++;
                $display("FAIL midrst_c%0d got=%h exp=%h", k, outs(), IDLE);
            end
        end
    endtask

    // s held high: ADD, one WAIT cycle, then the next instruction starts.
    task automatic test_back_to_back();
        logic [18:0] e[$];
        logic [15:0] x[$];
        e = '{DEC,
              v(0,3'd1,0,0,0,1,0,0,0,0,2'b00,2'b00,0),
              v(0,3'd0,0,0,0,0,1,0,0,0,2'b00,2'b00,0),
              v(0,0,0,0,0,0,0,1,0,0,2'b01,2'b00,0),
              v(0,0,3'd2,1,0,0,0,0,0,0,2'b00,2'b00,0),
              IDLE,
              DEC,
              v(0,0,3'd0,1,1,0,0,0,0,0,2'b00,2'b00,0),
              IDLE,
              IDLE};
        x = '{16'h0048, 16'h0048, 16'h0048, 16'h0048, 16'h0048, 16'h0048,
              16'h0005, 16'h0005, 16'h0005, 16'h0005};
        bus.instr = 16'hA148;
        bus.s     = 1'b1;
        step();
        bus.instr = 16'hD005;
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (outs() !== e[k] || bus.sximm8 !== x[k]) begin
                failures++;
                $display("FAIL b2b_c%0d got=%h/%h exp=%h/%h", k, outs(), bus.sximm8, e[k], x[k]);
            end
            if (k == 7) bus.s = 1'b0;
            step();
        end
    endtask

    initial begin
        IDLE = v(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0);
        DEC  = '0;
        test_reset();
        test_mov_imm(16'hD007, 3'd0, 16'h0007);
        test_mov_imm(16'hD1FE, 3'd1, 16'hFFFE);
        test_add();
        test_and();
        test_cmp_s_ignored();
        test_mov_reg(16'hC110, 3'd0, 3'd0, 16'h0010);
        test_mov_reg(16'hC097, 3'd7, 3'd4, 16'hFF97);
        test_mvn();
        test_bad();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
